// File: rtl/gpioemu_pkg.sv
// Shared definitions for the gpioemu host: peripheral register map, status encoding
// and the state encodings used by the job sequencer and the bus-access engine.
package gpioemu_pkg;

    localparam logic [15:0] ADDR_A1   = 16'h0380;
    localparam logic [15:0] ADDR_A2   = 16'h0388;
    localparam logic [15:0] ADDR_W    = 16'h0390;
    localparam logic [15:0] ADDR_L    = 16'h0398;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;

    localparam logic [1:0] STATUS_DONE = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_A1,
        ST_WR_A2,
        ST_WR_START,
        ST_POLL,
        ST_POLL_WAIT,
        ST_RD_W,
        ST_RD_L,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_STROBE,
        PH_HOLD
    } phase_e;

endpackage

// File: rtl/gpioemu_bus_cycle.sv
// One peripheral access: SETUP (combinational on start), STROBE_CYCLES of strobe, one HOLD.
// done_o pulses in HOLD, and rdata_o already carries the read word in that cycle.
module gpioemu_bus_cycle
    import gpioemu_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        is_read_i,
    input  logic [15:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] sdata_in_i,
    output logic [15:0] saddress_o,
    output logic        srd_o,
    output logic        swr_o,
    output logic [31:0] sdata_out_o,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        active_o
);

    localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);

    phase_e      phase_q, phase_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_read_q, is_read_d;
    logic [15:0] scnt_q, scnt_d;
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q   <= PH_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_read_q <= 1'b0;
            scnt_q    <= '0;
            rdata_q   <= '0;
        end else begin
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_read_q <= is_read_d;
            scnt_q    <= scnt_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_read_d   = is_read_q;
        scnt_d      = scnt_q;
        rdata_d     = rdata_q;
        saddress_o  = '0;
        sdata_out_o = '0;
        srd_o       = 1'b0;
        swr_o       = 1'b0;
        done_o      = 1'b0;
        case (phase_q)
            PH_IDLE: begin
                // The start cycle itself is the SETUP cycle, so back-to-back accesses have no gap.
                if (start_i) begin
                    saddress_o  = addr_i;
                    sdata_out_o = wdata_i;
                    addr_d      = addr_i;
                    wdata_d     = wdata_i;
                    is_read_d   = is_read_i;
                    scnt_d      = STROBE_LAST;
                    phase_d     = PH_STROBE;
                end
            end
            PH_STROBE: begin
                saddress_o  = addr_q;
                sdata_out_o = wdata_q;
                srd_o       = is_read_q;
                swr_o       = !is_read_q;
                if (scnt_q == 16'd0) begin
                    phase_d = PH_HOLD;
                end else begin
                    scnt_d = scnt_q - 16'd1;
                end
            end
            PH_HOLD: begin
                saddress_o  = addr_q;
                sdata_out_o = wdata_q;
                done_o      = 1'b1;
                phase_d     = PH_IDLE;
                if (is_read_q) begin
                    rdata_d = sdata_in_i;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    assign rdata_o  = (phase_q == PH_HOLD && is_read_q) ? sdata_in_i : rdata_q;
    assign active_o = (phase_q != PH_IDLE);

endmodule

// File: rtl/gpioemu_host.sv
// Host-side initiator for the gpioemu multiply/popcount peripheral: takes a job,
// runs the A1/A2/START/poll/W/L access sequence and returns the result.
module gpioemu_host
    import gpioemu_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int POLL_GAP      = 4,
    parameter int POLL_MAX      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_w,
    output logic [23:0] rsp_l,
    output logic        rsp_err,
    output logic [15:0] rsp_polls,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in,
    output logic        busy,
    output logic [15:0] job_count
);

    state_e      state_q, state_d;
    logic [23:0] a1_q, a1_d, a2_q, a2_d;
    logic [31:0] rsp_w_q, rsp_w_d;
    logic [23:0] rsp_l_q, rsp_l_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] polls_q, polls_d, polls_inc;
    logic [15:0] gap_q, gap_d;
    logic [15:0] job_count_q, job_count_d;

    logic        acc_req, acc_read, acc_start, acc_done, acc_active;
    logic [15:0] acc_addr;
    logic [31:0] acc_wdata, acc_rdata;

    gpioemu_bus_cycle #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (acc_start),
        .is_read_i   (acc_read),
        .addr_i      (acc_addr),
        .wdata_i     (acc_wdata),
        .sdata_in_i  (sdata_in),
        .saddress_o  (saddress),
        .srd_o       (srd),
        .swr_o       (swr),
        .sdata_out_o (sdata_out),
        .rdata_o     (acc_rdata),
        .done_o      (acc_done),
        .active_o    (acc_active)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a1_q        <= '0;
            a2_q        <= '0;
            rsp_w_q     <= '0;
            rsp_l_q     <= '0;
            rsp_err_q   <= 1'b0;
            polls_q     <= '0;
            gap_q       <= '0;
            job_count_q <= '0;
        end else begin
            state_q     <= state_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            rsp_w_q     <= rsp_w_d;
            rsp_l_q     <= rsp_l_d;
            rsp_err_q   <= rsp_err_d;
            polls_q     <= polls_d;
            gap_q       <= gap_d;
            job_count_q <= job_count_d;
        end
    end

    // Which access the current state needs; the engine is kicked whenever it is idle.
    always_comb begin
        acc_req   = 1'b0;
        acc_read  = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        case (state_q)
            ST_WR_A1:    begin acc_req = 1'b1; acc_addr = ADDR_A1;   acc_wdata = {8'h00, a1_q}; end
            ST_WR_A2:    begin acc_req = 1'b1; acc_addr = ADDR_A2;   acc_wdata = {8'h00, a2_q}; end
            ST_WR_START: begin acc_req = 1'b1; acc_addr = ADDR_CTRL; end
            ST_POLL:     begin acc_req = 1'b1; acc_addr = ADDR_CTRL; acc_read = 1'b1; end
            ST_RD_W:     begin acc_req = 1'b1; acc_addr = ADDR_W;    acc_read = 1'b1; end
            ST_RD_L:     begin acc_req = 1'b1; acc_addr = ADDR_L;    acc_read = 1'b1; end
            default:     ;
        endcase
    end

    assign acc_start = acc_req && !acc_active;
    assign polls_inc = (polls_q == 16'hFFFF) ? polls_q : polls_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        rsp_w_d     = rsp_w_q;
        rsp_l_d     = rsp_l_q;
        rsp_err_d   = rsp_err_q;
        polls_d     = polls_q;
        gap_d       = gap_q;
        job_count_d = job_count_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    a1_d      = cmd_a1;
                    a2_d      = cmd_a2;
                    rsp_w_d   = '0;
                    rsp_l_d   = '0;
                    rsp_err_d = 1'b0;
                    polls_d   = '0;
                    state_d   = ST_WR_A1;
                end
            end
            ST_WR_A1:    if (acc_done) state_d = ST_WR_A2;
            ST_WR_A2:    if (acc_done) state_d = ST_WR_START;
            ST_WR_START: if (acc_done) state_d = ST_POLL;
            ST_POLL: begin
                if (acc_done) begin
                    polls_d = polls_inc;
                    if (acc_rdata[1:0] == STATUS_DONE) begin
                        state_d = ST_RD_W;
                    end else if ({16'd0, polls_inc} >= 32'(POLL_MAX)) begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end else if (POLL_GAP == 0) begin
                        state_d = ST_POLL;
                    end else begin
                        gap_d   = 16'(POLL_GAP - 1);
                        state_d = ST_POLL_WAIT;
                    end
                end
            end
            ST_POLL_WAIT: begin
                if (gap_q == 16'd0) begin
                    state_d = ST_POLL;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            ST_RD_W: begin
                if (acc_done) begin
                    rsp_w_d = acc_rdata;
                    state_d = ST_RD_L;
                end
            end
            ST_RD_L: begin
                if (acc_done) begin
                    rsp_l_d = acc_rdata[23:0];
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    job_count_d = job_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_w     = rsp_w_q;
    assign rsp_l     = rsp_l_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_polls = polls_q;
    assign job_count = job_count_q;

endmodule

// File: tb/tb_gpioemu_host.sv
// Scoreboard bench for gpioemu_host: a small peripheral model answers the bus,
// expected bus accesses and responses are queued by the stimulus and checked by monitors.
module tb_gpioemu_host;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_a1 = '0;
    logic [23:0] cmd_a2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_w;
    logic [23:0] rsp_l;
    logic        rsp_err;
    logic [15:0] rsp_polls;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;
    logic        busy;
    logic [15:0] job_count;

    gpioemu_host dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a1    (cmd_a1),
        .cmd_a2    (cmd_a2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_w     (rsp_w),
        .rsp_l     (rsp_l),
        .rsp_err   (rsp_err),
        .rsp_polls (rsp_polls),
        .saddress  (saddress),
        .srd       (srd),
        .swr       (swr),
        .sdata_out (sdata_out),
        .sdata_in  (sdata_in),
        .busy      (busy),
        .job_count (job_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [15:0] addr;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        logic [31:0] w;
        logic [23:0] l;
        logic        err;
        logic [15:0] polls;
        int          lat;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    bus_t be;
    rsp_t re;
    rsp_t snap;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int rsp_seen = 0;
    int jc_exp = 0;
    int slow_n = 0;
    int status_reads = 0;
    int last_poll = -1;
    bit prev_strobe = 1'b0;
    bit strobe_now;
    bit in_rsp = 1'b0;
    bit chk_jc = 1'b0;
    logic [23:0] m_a1 = '0;
    logic [23:0] m_a2 = '0;
    logic [47:0] m_p;
    logic [31:0] m_w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Peripheral model: W is the low product word, L its ones count, STATUS done after slow_n reads.
    always_comb begin
        m_p = {24'd0, m_a1} * {24'd0, m_a2};
        m_w = m_p[31:0];
        case (saddress)
            16'h0390: sdata_in = m_w;
            16'h0398: sdata_in = {26'd0, 6'($countones(m_w))};
            16'h03A0: sdata_in = (status_reads > slow_n) ? 32'h3 : 32'h1;
            default:  sdata_in = 32'hDEAD_BEEF;
        endcase
    end

    // Bus monitor: one scoreboard entry per strobe.
    always @(negedge clk) begin
        strobe_now = srd | swr;
        if (strobe_now && !prev_strobe) begin
            chk("strobe_exclusive", 64'(srd & swr), 64'd0);
            if (swr && saddress == 16'h0380) begin
                m_a1         = sdata_out[23:0];
                status_reads = 0;
                last_poll    = -1;
            end
            if (swr && saddress == 16'h0388) m_a2 = sdata_out[23:0];
            if (srd && saddress == 16'h03A0) begin
                status_reads++;
                if (last_poll >= 0) chk("poll_spacing", 64'(cyc - last_poll), 64'd8);
                last_poll = cyc;
            end
            if (bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: rd=%0d addr 0x%0h, expected no access", srd, saddress);
            end else begin
                be = bus_q.pop_front();
                chk("bus_kind", 64'(srd), 64'(be.rd));
                chk("bus_addr", 64'(saddress), 64'(be.addr));
                if (!be.rd) chk("bus_wdata", 64'(sdata_out), 64'(be.data));
            end
        end
        prev_strobe = strobe_now;
    end

    // Response monitor: compares on first valid cycle, then checks stability until the handshake.
    always @(negedge clk) begin
        if (chk_jc) begin
            chk_jc = 1'b0;
            chk("job_count", 64'(job_count), 64'(jc_exp));
            chk("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
        end
        if (!reset && cmd_valid && cmd_ready) accept_cyc = cyc;
        if (reset) begin
            in_rsp = 1'b0;
        end else if (rsp_valid) begin
            if (!in_rsp) begin
                in_rsp     = 1'b1;
                snap.w     = rsp_w;
                snap.l     = rsp_l;
                snap.err   = rsp_err;
                snap.polls = rsp_polls;
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: w=0x%0h, expected no response", rsp_w);
                end else begin
                    re = rsp_q.pop_front();
                    chk("rsp_w", 64'(rsp_w), 64'(re.w));
                    chk("rsp_l", 64'(rsp_l), 64'(re.l));
                    chk("rsp_err", 64'(rsp_err), 64'(re.err));
                    chk("rsp_polls", 64'(rsp_polls), 64'(re.polls));
                    if (re.lat >= 0) chk("rsp_latency", 64'(cyc - accept_cyc), 64'(re.lat));
                end
            end else begin
                chk("hold_w", 64'(rsp_w), 64'(snap.w));
                chk("hold_l", 64'(rsp_l), 64'(snap.l));
                chk("hold_err", 64'(rsp_err), 64'(snap.err));
                chk("hold_polls", 64'(rsp_polls), 64'(snap.polls));
                chk("cmd_ready_stall", 64'(cmd_ready), 64'd0);
            end
            if (rsp_ready) begin
                in_rsp = 1'b0;
                jc_exp++;
                chk_jc = 1'b1;
                rsp_seen++;
            end
        end
    end

    task automatic issue(input logic [23:0] a1, input logic [23:0] a2);
        @(posedge clk);
        #1;
        cmd_a1    = a1;
        cmd_a2    = a2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_job(input logic [23:0] a1, input logic [23:0] a2, input int slow,
                           input int npolls, input logic err, input logic [31:0] w,
                           input logic [23:0] l, input int lat);
        int target;
        int n;
        slow_n = slow;
        bus_q.push_back('{1'b0, 16'h0380, {8'h00, a1}});
        bus_q.push_back('{1'b0, 16'h0388, {8'h00, a2}});
        bus_q.push_back('{1'b0, 16'h03A0, 32'h0});
        for (int i = 0; i < npolls; i++) bus_q.push_back('{1'b1, 16'h03A0, 32'h0});
        if (!err) begin
            bus_q.push_back('{1'b1, 16'h0390, 32'h0});
            bus_q.push_back('{1'b1, 16'h0398, 32'h0});
        end
        rsp_q.push_back('{w, l, err, 16'(npolls), lat});
        target = rsp_seen + 1;
        issue(a1, a2);
        n = 0;
        while (rsp_seen < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (rsp_seen < target) begin
            errors++;
            $display("FAIL job_done: no response after %0d cycles, expected one", n);
        end
        repeat (3) @(posedge clk);
        chk("bus_trace_left", 64'(bus_q.size()), 64'd0);
        chk("rsp_left", 64'(rsp_q.size()), 64'd0);
        bus_q.delete();
        rsp_q.delete();
    endtask

    task automatic release_after(input int stall);
        int n = 0;
        while (!rsp_valid && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (stall) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_strobes", 64'({srd, swr}), 64'd0);
        chk("reset_saddress", 64'(saddress), 64'd0);
        chk("reset_sdata_out", 64'(sdata_out), 64'd0);
        chk("reset_job_count", 64'(job_count), 64'd0);
        chk("reset_rsp_fields", {rsp_w, rsp_l, rsp_err, rsp_polls[6:0]}, 64'd0);
        reset = 1'b0;

        // Reset in the middle of the A2 write strobe discards the job.
        slow_n = 0;
        bus_q.push_back('{1'b0, 16'h0380, 32'h0000_0011});
        bus_q.push_back('{1'b0, 16'h0388, 32'h0000_0022});
        issue(24'h11, 24'h22);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(swr && saddress == 16'h0388) && n < 100);
        chk("a2_strobe_seen", 64'(swr && saddress == 16'h0388), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_strobes", 64'({srd, swr}), 64'd0);
        chk("midreset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_job_count", 64'(job_count), 64'(jc_exp));
        reset = 1'b0;
        repeat (3) @(posedge clk);
        chk("midreset_trace_left", 64'(bus_q.size()), 64'd0);
        bus_q.delete();

        run_job(24'h000003, 24'h000005, 0, 1, 1'b0, 32'd15, 24'd4, 25);
        run_job(24'hFFFFFF, 24'hFFFFFF, 0, 1, 1'b0, 32'hFE00_0001, 24'd8, 25);
        run_job(24'h001234, 24'h000100, 3, 4, 1'b0, 32'h0012_3400, 24'd5, -1);
        run_job(24'h000002, 24'h000002, 1000000, 64, 1'b1, 32'd0, 24'd0, -1);

        rsp_ready = 1'b0;
        fork
            run_job(24'h000007, 24'h000009, 0, 1, 1'b0, 32'd63, 24'd6, 25);
            release_after(10);
        join
        chk("final_job_count", 64'(job_count), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpioemu_host.md
Name: gpioemu_host

Overview:
- Bus initiator for the gpioemu multiply/popcount peripheral.
- Accepts a job (two 24-bit operands) on a valid/ready port, then drives the peripheral's saddress/srd/swr/sdata bus: writes A1 and A2, writes START, polls STATUS until done, reads W and L.
- Returns the results on a valid/ready response port.
- Sits on the host/testbench side, wired directly to the peripheral's slave bus.

Parameters:
- STROBE_CYCLES, 2: cycles srd/swr held high per access (≥1).
- POLL_GAP, 4: idle cycles between consecutive STATUS polls.
- POLL_MAX, 64: STATUS reads before declaring timeout (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  high only in IDLE
- cmd_a1  in  24  operand 1
- cmd_a2  in  24  operand 2
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_w  out  32  product word read from W
- rsp_l  out  24  ones count read from L
- rsp_err  out  1  1 = STATUS poll timeout
- rsp_polls  out  16  STATUS reads performed for this job
- saddress  out  16  peripheral register address
- srd  out  1  read strobe
- swr  out  1  write strobe
- sdata_out  out  32  write data to peripheral
- sdata_in  in  32  read data from peripheral
- busy  out  1  high when not IDLE
- job_count  out  16  completed jobs, wraps 0xFFFF→0

Behaviour:
- Reset values: every output 0 except cmd_ready=1; FSM in IDLE; job_count=0.
- Reset wins over all other events, including mid-access: srd/swr are 0 in the cycle after reset is sampled and the job is discarded.
- Register map:
  - A1 = 0x0380
  - A2 = 0x0388
  - W = 0x0390
  - L = 0x0398
  - CTRL/STATUS = 0x03A0
- Access timing, 2+STROBE_CYCLES cycles (4 at default):
  - SETUP, 1 cycle: saddress/sdata_out driven, strobes low.
  - STROBE, STROBE_CYCLES cycles: exactly one strobe high.
  - HOLD, 1 cycle: strobe low, saddress held.
  - Read data is captured from sdata_in on the first HOLD cycle.
  - srd and swr are never high together.
  - saddress is stable from SETUP through HOLD.
  - Between accesses, saddress = 0, sdata_out = 0, strobes low.
- Write data:
  - A1/A2 writes drive {8'h00, operand}.
  - The START write drives 0.
- cmd handshake:
  - On cmd_valid & cmd_ready, cmd_a1/cmd_a2 are latched and the FSM leaves IDLE in the same edge.
  - cmd_ready drops the next cycle.
- FSM:
  - IDLE → WR_A1 → WR_A2 → WR_START → POLL.
  - POLL: read 0x03A0.
    - If captured bits [1:0] == 2'b11 → RD_W.
    - Else if polls == POLL_MAX → RESP with rsp_err=1.
    - Else wait POLL_GAP cycles and poll again.
  - RD_W → RD_L → RESP.
  - RESP: rsp_valid=1 until rsp_valid & rsp_ready, then → IDLE and job_count+1.
- rsp fields:
  - rsp_w/rsp_l/rsp_err/rsp_polls are stable while rsp_valid is high.
  - rsp_l takes sdata_in[23:0].
  - On timeout: rsp_w=0, rsp_l=0, W/L are not read.
  - rsp_polls counts every STATUS read and saturates at 0xFFFF.
- The first poll read is issued in the cycle after the START write's HOLD; there is no gap before the first poll.
- A timeout job still increments job_count.
- Minimum latency, cmd accept to rsp_valid, at defaults with done on the first poll: 6 accesses × 4 + 1 = 25 cycles.

Decomposition:
- Package gpioemu_pkg:
  - register address constants (ADDR_A1, ADDR_A2, ADDR_W, ADDR_L, ADDR_CTRL)
  - STATUS_DONE = 2'b11
  - FSM state enum
- Sub-module gpioemu_bus_cycle performs one access.
  - Inputs: start, is_read, addr, wdata.
  - Outputs: saddress, srd, swr, sdata_out, rdata, done (1-cycle pulse on the last HOLD cycle).
  - The top FSM sequences accesses through it.

Test Plan:
- Functional: cmd a1=3, a2=5; model reports done on the first poll.
  - Bus trace: writes 0x380=0x3, 0x388=0x5, 0x3A0=0; reads 0x3A0, 0x390, 0x398.
  - Response: rsp_w=15, rsp_l=4, rsp_err=0, rsp_polls=1, rsp_valid 25 cycles after accept, job_count=1.
- Full-range operands: a1=a2=0xFFFFFF, model returns W=0xFE000001 and L=8 → rsp_w=0xFE000001, rsp_l=8.
- Slow peripheral: model STATUS=2'b01 for 3 reads, then 2'b11.
  - rsp_polls=4.
  - Consecutive poll accesses are separated by exactly POLL_GAP idle cycles.
- Timeout: STATUS never 2'b11.
  - Exactly 64 reads of 0x3A0, no reads of 0x390/0x398.
  - rsp_err=1, rsp_w=0, rsp_l=0.
- Backpressure and reset:
  - rsp_ready low for 10 cycles → rsp_valid held and fields stable; cmd_ready stays 0 until the handshake.
  - reset asserted mid-STROBE of WR_A2 → next cycle srd=swr=0, cmd_ready=1, job_count unchanged.
